uart_tx_streamer: RTL and testbench
===================================

// Module: uart_tx_streamer
// PURPOSE
// - Upstream feeder for the wishbone UART: takes a byte stream (valid/ready) from on-chip producers,
//   buffers it, and issues wishbone write cycles to the UART TX register (addr 0x00).
// - After reset, programs the UART frequency divider (addr 0x02) before sending any data.
// - Paces writes with a fixed inter-byte gap so the UART TX FIFO, which has no readable status, cannot overflow.
// PARAMETERS
// FIFO_DEPTH   16      input byte buffer depth; power of two, >= 2
// DIVIDER      8'd26   divider value written to UART addr 0x02 after reset
// GAP_CYCLES   160     idle wb_clk cycles after each completed TX write before the next byte write; >= 1
// ACK_TIMEOUT  255     max wb_clk cycles waiting for ack (rise or fall) before abort; >= 1
// PORTS
// wb_clk       in   1  clock; all logic on posedge
// reset        in   1  synchronous, active-high
// s_data       in   8  byte to transmit
// s_valid      in   1  s_data valid
// s_ready      out  1  buffer can accept; transfer when s_valid & s_ready
// cfg_div      in   8  runtime divider value
// cfg_div_wr   in   1  1-cycle pulse: request divider rewrite with cfg_div
// wb_addr      out  2  UART register address
// wb_data_out  out  8  write data to UART wb_data_in
// wb_we        out  1  0 = write (UART convention); always 0 from this block
// wb_stb       out  1  strobe
// wb_ack       in   1  UART ack; rises on accept, held until stb falls
// busy         out  1  1 when FSM is not IDLE or buffer is non-empty
// level        out  $clog2(FIFO_DEPTH)+1  bytes buffered
// timeout_err  out  1  sticky; set on any ack timeout, cleared only by reset
// BEHAVIOUR
// - Reset: wb_stb=0, wb_we=0, wb_addr=0, wb_data_out=0, timeout_err=0, level=0, s_ready=0 while in INIT states,
//   pending divider request cleared, FSM -> INIT_REQ. Reset mid-cycle drops stb immediately; buffered bytes are lost.
// - FIFO: s_ready = !full (and FSM not in INIT_*). Push and pop in the same cycle: level unchanged;
//   push on full ignored (cannot occur with s_ready honoured). Read/write pointers wrap modulo FIFO_DEPTH.
// - Divider request: cfg_div_wr latches cfg_div into div_pend and sets pend flag; a second pulse before service
//   overwrites the value (last wins). Pulse in the same cycle the request is serviced is retained as a new request.
// - FSM (registered outputs, one wishbone transaction at a time):
//   INIT_REQ: addr=2'b10, data=DIVIDER, stb=1 -> ACK_WAIT (ret=GAP skipped, goes IDLE).
//   IDLE: if pend -> DIV_REQ (priority over data); else if level>0 -> DATA_REQ (pop byte into wb_data_out, addr=2'b00).
//   DIV_REQ / DATA_REQ: drive stb=1 for the transaction -> ACK_WAIT.
//   ACK_WAIT: on wb_ack=1 drop stb next cycle -> REL_WAIT; counter > ACK_TIMEOUT -> stb=0, timeout_err=1, -> REL_WAIT.
//   REL_WAIT: wait wb_ack=0 (same timeout rule); data write -> GAP, divider/init write -> IDLE.
//   GAP: count GAP_CYCLES cycles with stb=0, then -> IDLE.
// - Latency: byte accepted into empty buffer with FSM idle -> wb_stb high 2 cycles later (push, then pop/request).
// - Timed-out data byte is discarded (not retried). Timeout counter resets on every state entry.
// - wb_addr/wb_data_out stable for the entire time wb_stb=1.
// STRUCTURE
// - Shared package uart_wb_pkg: UART address constants (TX 2'b00, RX 2'b01, DIV 2'b10), WE_WRITE=1'b0,
//   streamer FSM state encoding.
// - One sub-module: uart_stream_fifo (synchronous byte FIFO, depth FIFO_DEPTH, push/pop/full/empty/level).
// - Top holds FSM, gap/timeout counters, divider-request latch.
// TESTING
// - Reset release, ack after 1 cycle -> first transaction addr=2, data=0x1A, we=0; no data write before its ack falls.
// - Push 0x55,0xAA back-to-back -> two writes addr=0, data 0x55 then 0xAA, stb rise spacing >= GAP_CYCLES+4.
// - Push 17 bytes with UART ack stalled -> s_ready=0 at level=16; releasing acks drains all 16 bytes in order.
// - cfg_div_wr with 0x0C while bytes queued -> divider write (addr=2, data=0x0C) precedes next data write.
// - Ack tied low -> stb drops after ACK_TIMEOUT+1 cycles, timeout_err=1, byte dropped, next byte attempted.
// - Assert reset with stb high mid-transfer -> next cycle stb=0, level=0, re-runs divider init.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared definitions for the wishbone UART and its upstream feeders:
// register map, write-enable polarity and the TX streamer state encoding.
package uart_wb_pkg;

  localparam logic [1:0] UART_ADDR_TX  = 2'b00;
  localparam logic [1:0] UART_ADDR_RX  = 2'b01;
  localparam logic [1:0] UART_ADDR_DIV = 2'b10;

  // The UART treats we=0 as a write.
  localparam logic WE_WRITE = 1'b0;

  localparam logic [2:0] ST_INIT_REQ = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_DIV_REQ  = 3'd2;
  localparam logic [2:0] ST_DATA_REQ = 3'd3;
  localparam logic [2:0] ST_ACK_WAIT = 3'd4;
  localparam logic [2:0] ST_REL_WAIT = 3'd5;
  localparam logic [2:0] ST_GAP      = 3'd6;

endpackage

// File: rtl/uart_stream_fifo.sv
// Synchronous byte FIFO feeding the TX streamer. The head byte is visible
// on pop_data whenever the FIFO is non-empty.
module uart_stream_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   wb_clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_streamer.sv
// Buffers a valid/ready byte stream and writes it to the wishbone UART TX
// register, programming the baud divider first and pacing bytes by a fixed gap.
module uart_tx_streamer
  import uart_wb_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] DIVIDER     = 8'd26,
  parameter int         GAP_CYCLES  = 160,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic                        wb_clk,
  input  logic                        reset,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [7:0]                  cfg_div,
  input  logic                        cfg_div_wr,
  output logic [1:0]                  wb_addr,
  output logic [7:0]                  wb_data_out,
  output logic                        wb_we,
  output logic                        wb_stb,
  input  logic                        wb_ack,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        timeout_err
);

  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic          is_data_q, is_data_d;
  logic          init_q, init_d;
  logic          pend_q, pend_d;
  logic [7:0]    div_pend_q, div_pend_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;

  uart_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .wb_clk    (wb_clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign s_ready     = !fifo_full && !init_q;
  assign fifo_push   = s_valid && s_ready;
  assign wb_addr     = addr_q;
  assign wb_data_out = data_q;
  assign wb_stb      = stb_q;
  assign wb_we       = WE_WRITE;
  assign timeout_err = err_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

  // cnt_q counts cycles spent in the current state; it restarts on every entry,
  // so a wait gives up once ACK_TIMEOUT cycles have passed without progress.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    addr_d     = addr_q;
    data_d     = data_q;
    stb_d      = stb_q;
    err_d      = err_q;
    is_data_d  = is_data_q;
    init_d     = init_q;
    pend_d     = pend_q;
    div_pend_d = div_pend_q;
    fifo_pop   = 1'b0;

    if (cfg_div_wr) begin
      pend_d     = 1'b1;
      div_pend_d = cfg_div;
    end

    case (state_q)
      ST_INIT_REQ: begin
        addr_d    = UART_ADDR_DIV;
        data_d    = DIVIDER;
        stb_d     = 1'b1;
        is_data_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_ACK_WAIT;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_q) begin
          addr_d    = UART_ADDR_DIV;
          data_d    = div_pend_q;
          is_data_d = 1'b0;
          if (!cfg_div_wr) pend_d = 1'b0;
          state_d   = ST_DIV_REQ;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_d    = UART_ADDR_TX;
          data_d    = fifo_head;
          is_data_d = 1'b1;
          state_d   = ST_DATA_REQ;
        end
      end
      ST_DIV_REQ, ST_DATA_REQ: begin
        stb_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (wb_ack || (cnt_q == CW'(ACK_TIMEOUT))) begin
          if (!wb_ack) err_d = 1'b1;
          stb_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_REL_WAIT;
        end
      end
      ST_REL_WAIT: begin
        if (!wb_ack || (cnt_q == CW'(ACK_TIMEOUT))) begin
          if (wb_ack) err_d = 1'b1;
          init_d  = 1'b0;
          cnt_d   = '0;
          state_d = is_data_q ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        stb_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      state_q    <= ST_INIT_REQ;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      is_data_q  <= 1'b0;
      init_q     <= 1'b1;
      pend_q     <= 1'b0;
      div_pend_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      is_data_q  <= is_data_d;
      init_q     <= init_d;
      pend_q     <= pend_d;
      div_pend_q <= div_pend_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Directed bench for uart_tx_streamer: a simple UART ack responder plus a
// write monitor, with expected transactions worked out by hand.
module tb_uart_tx_streamer;

  localparam int GAP = 160;
  localparam int TO  = 255;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       we;
    int         rise;
  } wr_t;

  logic       wb_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] cfg_div = 8'h00;
  logic       cfg_div_wr = 1'b0;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack = 1'b0;
  logic       busy;
  logic [4:0] level;
  logic       timeout_err;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_push = 0;
  int  stab_err = 0;
  int  we_err = 0;
  bit  ack_en = 1'b0;
  wr_t wr_q[$];
  int  fall_q[$];

  uart_tx_streamer #(
    .FIFO_DEPTH(16), .DIVIDER(8'd26), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TO)
  ) dut (
    .wb_clk(wb_clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cfg_div(cfg_div), .cfg_div_wr(cfg_div_wr),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_we(wb_we),
    .wb_stb(wb_stb), .wb_ack(wb_ack), .busy(busy), .level(level),
    .timeout_err(timeout_err)
  );

  always #5 wb_clk = ~wb_clk;

  // UART model: ack one cycle after strobe, held until strobe drops.
  initial begin
    forever begin
      @(posedge wb_clk);
      #1;
      if (!wb_stb) wb_ack = 1'b0;
      else if (ack_en) wb_ack = 1'b1;
    end
  end

  initial begin
    logic       stb_prev;
    logic [1:0] hold_addr;
    logic [7:0] hold_data;
    wr_t        w;
    stb_prev  = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(posedge wb_clk);
      cyc++;
      #1;
      if (wb_stb && !stb_prev) begin
        w.addr = wb_addr; w.data = wb_data_out; w.we = wb_we; w.rise = cyc;
        wr_q.push_back(w);
        hold_addr = wb_addr;
        hold_data = wb_data_out;
      end else if (wb_stb && (wb_addr != hold_addr || wb_data_out != hold_data)) begin
        stab_err++;
      end
      if (!wb_stb && stb_prev) fall_q.push_back(cyc);
      if (wb_we) we_err++;
      stb_prev = wb_stb;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 2000) begin
      @(posedge wb_clk); #1; n++;
    end
    if (!s_ready) check_output("push_accept", 0, 1);
    @(posedge wb_clk); #1;
    last_push = cyc;
    s_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_q.size() < n && k < budget) begin
      @(posedge wb_clk); #2; k++;
    end
    check_output(tag, (wr_q.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_falls(input int n, input int budget, input string tag);
    int k = 0;
    while (fall_q.size() < n && k < budget) begin
      @(posedge wb_clk); #2; k++;
    end
    check_output(tag, (fall_q.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    @(posedge wb_clk); #2;
    while (busy && k < budget) begin
      @(posedge wb_clk); #2; k++;
    end
    check_output(tag, {31'd0, busy}, 0);
  endtask

  task automatic pulse_div(input logic [7:0] v);
    cfg_div    = v;
    cfg_div_wr = 1'b1;
    @(posedge wb_clk); #1;
    cfg_div_wr = 1'b0;
  endtask

  initial begin
    int base;
    int fbase;

    repeat (3) @(posedge wb_clk);
    #2;
    check_output("rst_stb", {31'd0, wb_stb}, 0);
    check_output("rst_we", {31'd0, wb_we}, 0);
    check_output("rst_addr", {30'd0, wb_addr}, 0);
    check_output("rst_data", {24'd0, wb_data_out}, 0);
    check_output("rst_err", {31'd0, timeout_err}, 0);
    check_output("rst_level", {27'd0, level}, 0);
    check_output("rst_ready", {31'd0, s_ready}, 0);
    check_output("rst_busy", {31'd0, busy}, 1);

    // Divider programmed first; the buffer stays closed until it completes.
    ack_en = 1'b1;
    reset  = 1'b0;
    wait_writes(1, 20, "init_wait");
    check_output("init_wr", {22'd0, wr_q[0].addr, wr_q[0].data}, {22'd0, 2'b10, 8'h1A});
    check_output("init_we", {31'd0, wr_q[0].we}, 0);
    check_output("init_ready", {31'd0, s_ready}, 0);
    wait_idle(50, "init_idle");
    check_output("idle_ready", {31'd0, s_ready}, 1);
    check_output("idle_level", {27'd0, level}, 0);

    // Two back-to-back bytes: 2-cycle latency, then paced by the gap.
    base = wr_q.size();
    apply_stimulus(8'h55);
    begin
      int p55;
      p55 = last_push;
      apply_stimulus(8'hAA);
      wait_writes(base + 2, 600, "pair_wait");
      check_output("pair_w0", {22'd0, wr_q[base].addr, wr_q[base].data}, {22'd0, 2'b00, 8'h55});
      check_output("pair_w1", {22'd0, wr_q[base+1].addr, wr_q[base+1].data}, {22'd0, 2'b00, 8'hAA});
      check_output("pair_latency", wr_q[base].rise - p55, 2);
      check_output("pair_spacing",
                   (wr_q[base+1].rise - wr_q[base].rise >= GAP + 4) ? 1 : 0, 1);
    end
    wait_idle(600, "pair_idle");

    // Fill with acks stalled: one byte in flight, sixteen buffered.
    base   = wr_q.size();
    ack_en = 1'b0;
    for (int i = 0; i < 17; i++) apply_stimulus(8'(8'h10 + i));
    check_output("full_level", {27'd0, level}, 16);
    check_output("full_ready", {31'd0, s_ready}, 0);
    check_output("full_err", {31'd0, timeout_err}, 0);
    ack_en = 1'b1;
    wait_writes(base + 17, 5000, "drain_wait");
    for (int i = 0; i < 17; i++) begin
      if (wr_q.size() > base + i)
        check_output($sformatf("drain_%0d", i),
                     {22'd0, wr_q[base+i].addr, wr_q[base+i].data},
                     {22'd0, 2'b00, 8'(8'h10 + i)});
    end
    wait_idle(600, "drain_idle");
    check_output("drain_err", {31'd0, timeout_err}, 0);

    // Divider request (last pulse wins) jumps ahead of queued data.
    base = wr_q.size();
    apply_stimulus(8'h31);
    apply_stimulus(8'h32);
    apply_stimulus(8'h33);
    pulse_div(8'h0B);
    @(posedge wb_clk); #1;
    pulse_div(8'h0C);
    wait_writes(base + 4, 1500, "div_wait");
    check_output("div_w0", {22'd0, wr_q[base].addr, wr_q[base].data}, {22'd0, 2'b00, 8'h31});
    check_output("div_w1", {22'd0, wr_q[base+1].addr, wr_q[base+1].data}, {22'd0, 2'b10, 8'h0C});
    check_output("div_w2", {22'd0, wr_q[base+2].addr, wr_q[base+2].data}, {22'd0, 2'b00, 8'h32});
    check_output("div_w3", {22'd0, wr_q[base+3].addr, wr_q[base+3].data}, {22'd0, 2'b00, 8'h33});
    wait_idle(600, "div_idle");

    // Ack tied low: each byte times out and is dropped.
    base   = wr_q.size();
    fbase  = fall_q.size();
    ack_en = 1'b0;
    apply_stimulus(8'h77);
    apply_stimulus(8'h78);
    wait_falls(fbase + 1, 400, "to_fall0");
    check_output("to_hold", fall_q[fbase] - wr_q[base].rise, TO + 1);
    check_output("to_err", {31'd0, timeout_err}, 1);
    wait_writes(base + 2, 600, "to_next");
    check_output("to_w1", {22'd0, wr_q[base+1].addr, wr_q[base+1].data}, {22'd0, 2'b00, 8'h78});
    wait_idle(1200, "to_idle");
    check_output("to_count", wr_q.size() - base, 2);
    check_output("to_level", {27'd0, level}, 0);

    // Reset while strobing: transfer abandoned, buffer emptied, init re-run.
    base = wr_q.size();
    apply_stimulus(8'h99);
    apply_stimulus(8'h9A);
    apply_stimulus(8'h9B);
    wait_writes(base + 1, 20, "mid_wait");
    repeat (3) @(posedge wb_clk);
    #2;
    check_output("mid_stb_hi", {31'd0, wb_stb}, 1);
    reset = 1'b1;
    @(posedge wb_clk); #2;
    check_output("mid_stb", {31'd0, wb_stb}, 0);
    check_output("mid_level", {27'd0, level}, 0);
    check_output("mid_err", {31'd0, timeout_err}, 0);
    check_output("mid_ready", {31'd0, s_ready}, 0);
    reset  = 1'b0;
    ack_en = 1'b1;
    wait_writes(base + 2, 20, "mid_init");
    check_output("mid_init_wr", {22'd0, wr_q[base+1].addr, wr_q[base+1].data},
                 {22'd0, 2'b10, 8'h1A});
    wait_idle(100, "mid_idle");
    check_output("mid_count", wr_q.size() - base, 2);

    check_output("addr_data_stable", stab_err, 0);
    check_output("we_always_write", we_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
